// File: rtl/ad_decimator.sv
// Boxcar accumulate-and-dump decimator: averages 2^k consecutive 8-channel sample vectors.
// Optional define AD_DEC_ROUND_EN selects round-half-up averaging instead of floor.
module ad_decimator #(
  parameter int AD_DATA_NBIT = 16,
  parameter int AD_CHN_NUM   = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               en,
  input  logic [2:0]                         dec_log2,
  input  logic                               in_vd,
  input  logic [AD_CHN_NUM*AD_DATA_NBIT-1:0] in_data,
  output logic                               out_vd,
  output logic [AD_CHN_NUM*AD_DATA_NBIT-1:0] out_data,
  output logic [15:0]                        out_blk_cnt,
  output logic                               busy
);

  localparam int W  = AD_DATA_NBIT;
  localparam int AW = AD_DATA_NBIT + 7;
  localparam int DW = AD_CHN_NUM * AD_DATA_NBIT;

  typedef enum logic {S_IDLE, S_ACC} state_t;

  state_t                r_state, w_state_nxt;
  logic [6:0]            r_cnt;
  logic [2:0]            r_k_act;
  logic signed [AW-1:0]  r_acc [AD_CHN_NUM];
  logic                  r_out_vd;
  logic [DW-1:0]         r_out_data;
  logic [15:0]           r_out_blk_cnt;

  logic signed [AW-1:0]  w_sum [AD_CHN_NUM];
  logic signed [AW-1:0]  w_rnd;
  logic [DW-1:0]         w_avg;
  logic [6:0]            w_cnt_last;

  // Index of the last sample in a block: N-1 = low k_act bits set.
  assign w_cnt_last = ~(7'h7F << r_k_act);

`ifdef AD_DEC_ROUND_EN
  assign w_rnd = AW'((8'd1 << r_k_act) >> 1);
`else
  assign w_rnd = '0;
`endif

  always_comb begin
    logic signed [AW-1:0] v_shift;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_avg   = '0;
    v_shift = '0;
    for (int c = 0; c < AD_CHN_NUM; c++) begin
      w_sum[c] = r_acc[c] + AW'(signed'(in_data[c*W +: W]));
      v_shift  = (w_sum[c] + w_rnd) >>> r_k_act;
      w_avg[c*W +: W] = v_shift[W-1:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (en)  w_state_nxt = S_ACC;
      S_ACC:  if (!en) w_state_nxt = S_IDLE;
      default:         w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the accumulator array is flip-flops, not RAM, so it is reset like any other register.
      for (int c = 0; c < AD_CHN_NUM; c++) r_acc[c] <= '0;
      r_cnt         <= '0;
      r_k_act       <= '0;
      r_out_vd      <= 1'b0;
      r_out_data    <= '0;
      r_out_blk_cnt <= '0;
    end else begin
      r_out_vd <= 1'b0;
      if (r_state == S_IDLE || !en) begin
        // Idle, or enable dropping: flush any partial block without emitting it.
        for (int c = 0; c < AD_CHN_NUM; c++) r_acc[c] <= '0;
        r_cnt <= '0;
        if (r_state == S_IDLE) r_k_act <= dec_log2;
      end else if (in_vd) begin
        if (r_cnt == w_cnt_last) begin
          for (int c = 0; c < AD_CHN_NUM; c++) r_acc[c] <= '0;
          r_cnt         <= '0;
          r_out_data    <= w_avg;
          r_out_vd      <= 1'b1;
          r_out_blk_cnt <= r_out_blk_cnt + 16'd1;
          r_k_act       <= dec_log2;
        end else begin
          for (int c = 0; c < AD_CHN_NUM; c++) r_acc[c] <= w_sum[c];
          r_cnt <= r_cnt + 7'd1;
        end
      end
    end
  end

  assign out_vd      = r_out_vd;
  assign out_data    = r_out_data;
  assign out_blk_cnt = r_out_blk_cnt;
  assign busy        = (r_state == S_ACC) && (r_cnt != 7'd0);

endmodule

// File: tb/tb_ad_decimator.sv
// Directed self-checking bench for ad_decimator with hand-computed expected vectors.
module tb_ad_decimator;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int DW = W * N;

`ifdef AD_DEC_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [2:0]    dec_log2;
  logic          in_vd;
  logic [DW-1:0] in_data;
  logic          out_vd;
  logic [DW-1:0] out_data;
  logic [15:0]   out_blk_cnt;
  logic          busy;

  int n_vec  = 0;
  int n_err  = 0;
  int vd_cnt = 0;
  int vd_snap;

  ad_decimator #(.AD_DATA_NBIT(W), .AD_CHN_NUM(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .dec_log2    (dec_log2),
    .in_vd       (in_vd),
    .in_data     (in_data),
    .out_vd      (out_vd),
    .out_data    (out_data),
    .out_blk_cnt (out_blk_cnt),
    .busy        (busy)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (out_vd === 1'b1) vd_cnt++;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] all(input logic [W-1:0] v);
    return {N{v}};
  endfunction

  function automatic logic [DW-1:0] ch(input int c, input logic [W-1:0] v);
    logic [DW-1:0] r;
    r = '0;
    r[c*W +: W] = v;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] v);
    in_vd   = 1'b1;
    in_data = v;
    step();
  endtask

  task automatic rest();
    in_vd = 1'b0;
    step();
  endtask

  task automatic restart(input logic [2:0] k);
    en    = 1'b0;
    in_vd = 1'b0;
    step();
    dec_log2 = k;
    en       = 1'b1;
    step();
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    dec_log2 = 3'd0;
    in_vd    = 1'b0;
    in_data  = '0;
    step();
    step();
    check("rst_out_vd",  DW'(out_vd),      '0);
    check("rst_out_data", out_data,        '0);
    check("rst_blk_cnt", DW'(out_blk_cnt), '0);
    check("rst_busy",    DW'(busy),        '0);
    rst_n = 1'b1;
    step();

    // k=0 pass-through, back-to-back samples
    restart(3'd0);
    send(ch(0, 16'h1234) | ch(7, 16'hABCD));
    check("k0_vd1",   DW'(out_vd), DW'(1));
    check("k0_data1", out_data, ch(0, 16'h1234) | ch(7, 16'hABCD));
    send(ch(0, 16'h8000));
    check("k0_vd2",   DW'(out_vd), DW'(1));
    check("k0_data2", out_data, ch(0, 16'h8000));
    check("k0_blk",   DW'(out_blk_cnt), DW'(2));
    rest();
    check("k0_vd_drop", DW'(out_vd), '0);
    check("k0_hold",    out_data, ch(0, 16'h8000));

    // k=2 on ch0: 1,2,3,4 -> 2.5
    restart(3'd2);
    send(ch(0, 16'd1));
    check("k2_busy",  DW'(busy),   DW'(1));
    check("k2_novd",  DW'(out_vd), '0);
    send(ch(0, 16'd2));
    send(ch(0, 16'd3));
    send(ch(0, 16'd4));
    check("k2_vd",    DW'(out_vd), DW'(1));
    check("k2_data",  out_data, ch(0, RND ? 16'd3 : 16'd2));
    check("k2_blk",   DW'(out_blk_cnt), DW'(3));
    check("k2_idle",  DW'(busy), '0);

    // k=1 on ch3: -3,-2 -> -2.5
    restart(3'd1);
    send(ch(3, 16'hFFFD));
    send(ch(3, 16'hFFFE));
    check("k1_vd",   DW'(out_vd), DW'(1));
    check("k1_data", out_data, ch(3, RND ? 16'hFFFE : 16'hFFFD));

    // k=7 full-scale extremes, no wrap
    restart(3'd7);
    vd_snap = vd_cnt;
    for (int i = 0; i < 127; i++) send(all(16'h7FFF));
    check("k7_pre_vd",   DW'(out_vd), '0);
    check("k7_pre_busy", DW'(busy),   DW'(1));
    send(all(16'h7FFF));
    check("k7_pos", out_data, all(16'h7FFF));
    for (int i = 0; i < 128; i++) send(all(16'h8000));
    check("k7_neg", out_data, all(16'h8000));
    check("k7_vd",  DW'(out_vd), DW'(1));
    rest();
    check("k7_pulses", DW'(vd_cnt - vd_snap), DW'(2));
    check("k7_blk",    DW'(out_blk_cnt), DW'(6));

    // partial block discarded by en drop, then a clean block
    restart(3'd2);
    send(all(16'd8));
    check("fl_busy1", DW'(busy), DW'(1));
    send(all(16'd8));
    en    = 1'b0;
    in_vd = 1'b0;
    step();
    check("fl_busy_idle", DW'(busy),   '0);
    check("fl_novd",      DW'(out_vd), '0);
    vd_snap = vd_cnt;
    en = 1'b1;
    step();
    for (int i = 0; i < 4; i++) send(all(16'd8));
    check("fl_vd",   DW'(out_vd), DW'(1));
    check("fl_data", out_data, all(16'd8));
    rest();
    check("fl_busy_end", DW'(busy), '0);
    check("fl_pulses",   DW'(vd_cnt - vd_snap), DW'(1));
    check("fl_blk",      DW'(out_blk_cnt), DW'(7));

    // en falls in the same cycle as the completing sample
    restart(3'd1);
    send(all(16'd2));
    in_vd   = 1'b1;
    in_data = all(16'd2);
    en      = 1'b0;
    step();
    in_vd = 1'b0;
    check("ef_novd", DW'(out_vd), '0);
    check("ef_blk",  DW'(out_blk_cnt), DW'(7));
    check("ef_hold", out_data, all(16'd8));

    // dec_log2 change mid-block waits for the boundary
    restart(3'd2);
    send(all(16'd4));
    dec_log2 = 3'd0;
    send(all(16'd4));
    check("dc_novd2", DW'(out_vd), '0);
    send(all(16'd4));
    check("dc_novd3", DW'(out_vd), '0);
    send(all(16'd8));
    check("dc_vd",   DW'(out_vd), DW'(1));
    check("dc_data", out_data, all(16'd5));
    send(all(16'h0011));
    check("dc_k0_a", out_data, all(16'h0011));
    send(all(16'h0022));
    check("dc_k0_b", out_data, all(16'h0022));
    check("dc_blk",  DW'(out_blk_cnt), DW'(10));
    rest();

    // async reset mid-block
    restart(3'd2);
    send(all(16'd1));
    rest();
    check("rs_busy_pre", DW'(busy), DW'(1));
    rst_n = 1'b0;
    #1;
    check("rs_blk",  DW'(out_blk_cnt), '0);
    check("rs_busy", DW'(busy),        '0);
    check("rs_data", out_data,         '0);
    check("rs_vd",   DW'(out_vd),      '0);
    step();
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
